cim_row_ctrl: RTL
=================

Name: cim_row_ctrl

Overview:
- Access sequencer for the 4-row CIM array's row decoder.
- Accepts one read, write or MAC request at a time over a valid/ready handshake and drives the decoder's MAC_en, read_bar, w_en, CS, addr and data pins through the phases SETUP, ACTIVE, PRECHARGE and DONE.
- Pulses the sense-amp enable for reads and MACs, and reports completion to the requester.
- Sits between the macro's host interface and row_decoder; it is the only driver of the decoder's control pins.

Parameters:
- ACT_CYCLES, 2, cycles CS stays high (word-line active window); legal 1..15.
- PRE_CYCLES, 1, bitline precharge/recovery cycles after ACTIVE; legal 0..15.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept; high only in IDLE.
- req_op  input  2  00 read, 01 write, 10 MAC, 11 illegal.
- req_addr  input  2  target row (read/write).
- req_data  input  4  write data or MAC input vector.
- MAC_en  output  1  to row_decoder.
- read_bar  output  1  to row_decoder; low = read.
- w_en  output  1  to row_decoder.
- CS  output  1  to row_decoder; high = array selected.
- addr  output  2  to row_decoder.
- data  output  4  to row_decoder.
- sa_en  output  1  sense-amp strobe.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  qualifies resp_valid; 1 = illegal op.

Behaviour:
- Reset (rst=1 at a clock edge), taking effect from that edge:
  - State goes to IDLE.
  - MAC_en=0, read_bar=1, w_en=0, CS=0, addr=0, data=0, sa_en=0, resp_valid=0, resp_err=0, req_ready=1.
  - Reset mid-operation abandons the access immediately with no resp_valid; CS drops the same edge.
- IDLE: req_ready=1 and decoder pins hold idle values. On req_valid&&req_ready at edge t, latch op/addr/data and go to SETUP.
- SETUP (exactly 1 cycle, t+1):
  - addr and data driven from the latches. CS=0.
  - Mode pins set per op:
    - read: read_bar=0.
    - write: w_en=1.
    - MAC: MAC_en=1, read_bar=0.
    - illegal: all idle.
  - Next state is ACTIVE, or DONE for an illegal op.
- ACTIVE (ACT_CYCLES cycles):
  - CS=1; mode pins, addr and data held stable.
  - 4-bit counter counts ACT_CYCLES-1 down to 0.
  - sa_en=1 only in the final ACTIVE cycle, and only for read/MAC.
  - When count reaches 0, go to PRECHARGE, or to DONE if PRE_CYCLES=0.
- PRECHARGE (PRE_CYCLES cycles):
  - CS=0; MAC_en=0, w_en=0, read_bar=1; addr/data held.
  - Counter counts PRE_CYCLES-1 down to 0, then goes to DONE.
- DONE (1 cycle): resp_valid=1, resp_err=1 iff op was 11; all pins idle; then IDLE.
- Latency, accept edge to resp_valid cycle:
  - legal op: 2+ACT_CYCLES+PRE_CYCLES cycles; 5 with defaults.
  - illegal op: 2 cycles.
- Throughput: req_ready rises the cycle after DONE, so back-to-back requests are separated by one IDLE cycle. The minimum period with defaults is 6 cycles.
- Request inputs are ignored outside IDLE; changing them mid-access has no effect on the outputs.
- Invariants:
  - CS=1 never coincides with a change of addr, data or mode pins.
  - w_en and MAC_en are never both 1.
  - Never more than one of read, write or MAC active.
- All outputs are registered; no combinational path from req_* to decoder pins.

Test Plan:
- Reset: hold rst for 2 cycles mid-ACTIVE of a write -> next cycle CS=0, w_en=0, read_bar=1, req_ready=1, and no resp_valid.
- Write, defaults: op=01, addr=2, data=1010 accepted at t -> t+1 w_en=1, addr=2, data=1010, CS=0; t+2..t+3 CS=1; t+4 CS=0, w_en=0; t+5 resp_valid=1, resp_err=0; t+6 req_ready=1.
- Read, defaults: op=00, addr=1 -> read_bar=0 from t+1 to t+3; sa_en=1 only at t+3; resp_valid at t+5.
- MAC with ACT_CYCLES=3, PRE_CYCLES=0: data=0110 -> MAC_en=1 and read_bar=0 t+1..t+4; CS=1 t+2..t+4; sa_en at t+4; resp_valid at t+5.
- Illegal op=11 -> no CS pulse, all pins idle; resp_valid=1 and resp_err=1 at t+2.
- Back-to-back: req_valid held high with a write then a read -> second accept exactly 1 cycle after the first resp_valid; req_ready=0 throughout the first access; second request's inputs changing during the first access have no effect.

Source files
------------

// File: rtl/cim_row_ctrl.sv
// cim_row_ctrl: access sequencer for the 4-row CIM array's row decoder.
// Accepts one read / write / MAC request at a time and steps the decoder
// pins through SETUP -> ACTIVE -> PRECHARGE -> DONE. It is the only driver of
// the decoder's control pins, and every output comes straight from a flop.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op                00 read, 01 write, 10 MAC, 11 illegal
//   req_addr, req_data    target row, and write data or MAC input vector
//   MAC_en, read_bar,
//   w_en, CS, addr, data  row_decoder pins
//   sa_en                 sense-amp strobe (last ACTIVE cycle of read/MAC)
//   resp_valid, resp_err  one-cycle completion pulse; err = illegal op
module cim_row_ctrl #(
  parameter int ACT_CYCLES = 2,
  parameter int PRE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [1:0] req_addr,
  input  logic [3:0] req_data,
  output logic       MAC_en,
  output logic       read_bar,
  output logic       w_en,
  output logic       CS,
  output logic [1:0] addr,
  output logic [3:0] data,
  output logic       sa_en,
  output logic       resp_valid,
  output logic       resp_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACTIVE, S_PRE, S_DONE
  } state_t;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [3:0] ACT_LOAD = 4'(ACT_CYCLES - 1);
  localparam logic [3:0] PRE_LOAD = 4'(PRE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [1:0] addr_lat_q, addr_lat_d;
  logic [3:0] data_lat_q, data_lat_d;

  logic       req_ready_q, req_ready_d;
  logic       mac_en_q, mac_en_d;
  logic       read_bar_q, read_bar_d;
  logic       w_en_q, w_en_d;
  logic       cs_q, cs_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;
  logic       sa_en_q, sa_en_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_err_q, resp_err_d;

  // Next state, counter and request latches
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_lat_d = addr_lat_q;
    data_lat_d = data_lat_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d       = req_op;
          addr_lat_d = req_addr;
          data_lat_d = req_data;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (op_q == OP_ILL) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ACTIVE;
          cnt_d   = ACT_LOAD;
        end
      end
      S_ACTIVE: begin
        if (cnt_q == 4'd0) begin
          if (PRE_CYCLES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PRE;
            cnt_d   = PRE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_PRE: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they can be
  // registered without adding a cycle of latency. Mode pins, addr and data
  // are identical in SETUP and ACTIVE, so nothing moves while CS is high.
  always_comb begin
    req_ready_d  = 1'b0;
    mac_en_d     = 1'b0;
    read_bar_d   = 1'b1;
    w_en_d       = 1'b0;
    cs_d         = 1'b0;
    addr_d       = 2'd0;
    data_d       = 4'd0;
    sa_en_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    case (state_d)
      S_IDLE: req_ready_d = 1'b1;
      S_SETUP, S_ACTIVE: begin
        addr_d = addr_lat_d;
        data_d = data_lat_d;
        cs_d   = (state_d == S_ACTIVE);
        case (op_d)
          OP_RD:   read_bar_d = 1'b0;
          OP_WR:   w_en_d     = 1'b1;
          OP_MAC: begin
            mac_en_d   = 1'b1;
            read_bar_d = 1'b0;
          end
          default: ;
        endcase
        sa_en_d = (state_d == S_ACTIVE) && (cnt_d == 4'd0) &&
                  ((op_d == OP_RD) || (op_d == OP_MAC));
      end
      S_PRE: begin
        addr_d = addr_lat_d;
        data_d = data_lat_d;
      end
      S_DONE: begin
        resp_valid_d = 1'b1;
        resp_err_d   = (op_d == OP_ILL);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      op_q         <= OP_RD;
      req_ready_q  <= 1'b1;
      mac_en_q     <= 1'b0;
      read_bar_q   <= 1'b1;
      w_en_q       <= 1'b0;
      cs_q         <= 1'b0;
      addr_q       <= 2'd0;
      data_q       <= 4'd0;
      sa_en_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      req_ready_q  <= req_ready_d;
      mac_en_q     <= mac_en_d;
      read_bar_q   <= read_bar_d;
      w_en_q       <= w_en_d;
      cs_q         <= cs_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      sa_en_q      <= sa_en_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Request latches only carry data; they are always rewritten at accept.
  always_ff @(posedge clk) begin
    addr_lat_q <= addr_lat_d;
    data_lat_q <= data_lat_d;
  end

  assign req_ready  = req_ready_q;
  assign MAC_en     = mac_en_q;
  assign read_bar   = read_bar_q;
  assign w_en       = w_en_q;
  assign CS         = cs_q;
  assign addr       = addr_q;
  assign data       = data_q;
  assign sa_en      = sa_en_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;

endmodule
